// File: rtl/mips_debug_ctrl.sv
// UART-side debug controller for the pipelined MIPS core: program load, breakpoint,
// run/step control and a byte-serial dump of registers, pipeline latches and data memory.
module mips_debug_ctrl #(
   parameter int                 NB_WORD    = 32,
   parameter int                 N_REGS     = 32,
   parameter int                 N_LATCH    = 4,
   parameter int                 N_MEM      = 32,
   parameter int                 IMEM_DEPTH = 256,
   parameter logic [NB_WORD-1:0] HALT_CODE  = 32'h3F
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [7:0]         i_rx_data,
   input  logic               i_rx_valid,
   output logic               o_rx_ready,
   output logic [7:0]         o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready,
   input  logic               i_halt,
   input  logic [NB_WORD-1:0] i_pc,
   input  logic [NB_WORD-1:0] i_reg_data,
   input  logic [NB_WORD-1:0] i_latch_data,
   input  logic [NB_WORD-1:0] i_mem_data,
   output logic [NB_WORD-1:0] o_rd_idx,
   output logic               o_imem_we,
   output logic [NB_WORD-1:0] o_imem_addr,
   output logic [NB_WORD-1:0] o_imem_data,
   output logic               o_enable,
   output logic               o_reset_mips
);
   localparam int NBY = NB_WORD / 8;
   localparam int BW  = (NBY > 1) ? $clog2(NBY) : 1;
   localparam logic [NB_WORD-1:0] LAST_ADDR = NB_WORD'(4 * (IMEM_DEPTH - 1));

   typedef enum logic [3:0] {
      IDLE, CMD, LOAD, LOAD_WR, BRK, RUN, STEP,
      DUMP_REG, DUMP_LATCH, DUMP_MEM, DUMP_SUM, RST_CPU
   } state_t;

   state_t             state_q;
   logic [7:0]         cmd_q, csum_q;
   logic [NB_WORD-1:0] sh_q, addr_q, brk_q, idx_q;
   logic [BW-1:0]      byte_q;
   logic               brk_en_q;

   logic [NB_WORD-1:0] sh_d, dump_word;
   logic [7:0]         tx_byte;
   logic               act, rx_hs, tx_hs, bp_hit, last_byte, sec_last;
   state_t             sec_next;

   // Every output is forced low while reset is asserted, including state decodes.
   assign act       = ~i_reset;
   assign sh_d      = (sh_q << 8) | NB_WORD'(i_rx_data);
   assign rx_hs     = o_rx_ready & i_rx_valid;
   assign tx_hs     = o_tx_valid & i_tx_ready;
   assign bp_hit    = brk_en_q & (i_pc == brk_q);
   assign last_byte = (byte_q == BW'(NBY - 1));

   always_comb begin
      dump_word = '0;
      sec_last  = 1'b0;
      sec_next  = IDLE;
      case (state_q)
         DUMP_REG:   begin dump_word = i_reg_data;   sec_last = (idx_q == NB_WORD'(N_REGS - 1));  sec_next = DUMP_LATCH; end
         DUMP_LATCH: begin dump_word = i_latch_data; sec_last = (idx_q == NB_WORD'(N_LATCH - 1)); sec_next = DUMP_MEM;   end
         DUMP_MEM:   begin dump_word = i_mem_data;   sec_last = (idx_q == NB_WORD'(N_MEM - 1));   sec_next = DUMP_SUM;   end
         default:    ;
      endcase
   end

   // byte_q counts from the most significant byte downwards.
   always_comb begin
      tx_byte = '0;
      for (int b = 0; b < NBY; b++)
         if (byte_q == BW'(NBY - 1 - b)) tx_byte = dump_word[8*b +: 8];
   end

   assign o_rx_ready   = act & (state_q inside {IDLE, LOAD, BRK});
   assign o_tx_valid   = act & (state_q inside {DUMP_REG, DUMP_LATCH, DUMP_MEM, DUMP_SUM});
   assign o_tx_data    = act ? ((state_q == DUMP_SUM) ? csum_q : tx_byte) : 8'h00;
   assign o_imem_we    = act & (state_q == LOAD_WR);
   assign o_reset_mips = act & (state_q == RST_CPU);
   assign o_enable     = act & (((state_q == RUN)  & ~(i_halt | bp_hit)) |
                                ((state_q == STEP) & ~i_halt));
   assign o_imem_addr  = addr_q;
   assign o_imem_data  = sh_q;
   assign o_rd_idx     = idx_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= IDLE;
         cmd_q    <= '0;
         sh_q     <= '0;
         addr_q   <= '0;
         brk_q    <= '0;
         brk_en_q <= 1'b0;
         idx_q    <= '0;
         byte_q   <= '0;
         csum_q   <= '0;
      end else begin
         case (state_q)
            IDLE: if (rx_hs) begin
               cmd_q   <= i_rx_data;
               state_q <= CMD;
            end
            CMD: begin
               byte_q <= '0;
               idx_q  <= '0;
               csum_q <= '0;
               case (cmd_q)
                  8'h04:   state_q <= LOAD;
                  8'h05:   state_q <= STEP;
                  8'h03:   state_q <= RUN;
                  8'h0C:   state_q <= RST_CPU;
                  8'h0E:   state_q <= BRK;
                  8'h0F:   state_q <= DUMP_REG;
                  default: state_q <= IDLE;
               endcase
            end
            LOAD: if (rx_hs) begin
               sh_q   <= sh_d;
               byte_q <= last_byte ? '0 : byte_q + BW'(1);
               if (last_byte) state_q <= LOAD_WR;
            end
            LOAD_WR: begin
               if (sh_q == HALT_CODE || addr_q == LAST_ADDR) begin
                  addr_q  <= '0;
                  state_q <= IDLE;
               end else begin
                  addr_q  <= addr_q + NB_WORD'(4);
                  state_q <= LOAD;
               end
            end
            BRK: if (rx_hs) begin
               sh_q   <= sh_d;
               byte_q <= last_byte ? '0 : byte_q + BW'(1);
               if (last_byte) begin
                  brk_q    <= sh_d;
                  brk_en_q <= (sh_d != '1);
                  state_q  <= IDLE;
               end
            end
            RUN:  if (i_halt | bp_hit) state_q <= DUMP_REG;
            STEP: state_q <= DUMP_REG;
            DUMP_REG, DUMP_LATCH, DUMP_MEM: if (tx_hs) begin
               csum_q <= csum_q ^ tx_byte;
               byte_q <= last_byte ? '0 : byte_q + BW'(1);
               if (last_byte) begin
                  if (sec_last) begin
                     idx_q   <= '0;
                     state_q <= sec_next;
                  end else begin
                     idx_q <= idx_q + NB_WORD'(1);
                  end
               end
            end
            DUMP_SUM: if (tx_hs) begin
               csum_q  <= '0;
               state_q <= IDLE;
            end
            RST_CPU: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Scenario bench for mips_debug_ctrl: a small CPU/memory model, byte monitors and an
// array-based reference for the expected dump stream.
module tb_mips_debug_ctrl;
   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic [7:0]  i_rx_data = 8'h00;
   logic        i_rx_valid = 1'b0;
   logic        o_rx_ready;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid;
   logic        i_tx_ready = 1'b1;
   logic        i_halt;
   logic [31:0] i_pc;
   logic [31:0] i_reg_data, i_latch_data, i_mem_data;
   logic [31:0] o_rd_idx;
   logic        o_imem_we;
   logic [31:0] o_imem_addr, o_imem_data;
   logic        o_enable;
   logic        o_reset_mips;

   mips_debug_ctrl dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
      .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
      .i_halt(i_halt), .i_pc(i_pc),
      .i_reg_data(i_reg_data), .i_latch_data(i_latch_data), .i_mem_data(i_mem_data),
      .o_rd_idx(o_rd_idx), .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr),
      .o_imem_data(o_imem_data), .o_enable(o_enable), .o_reset_mips(o_reset_mips)
   );

   always #5 i_clk = ~i_clk;

   // Environment: memories answer combinationally at o_rd_idx.
   logic [31:0] regs [32];
   logic [31:0] latw [4];
   logic [31:0] memw [32];
   assign i_reg_data   = regs[o_rd_idx[4:0]];
   assign i_latch_data = latw[o_rd_idx[1:0]];
   assign i_mem_data   = memw[o_rd_idx[4:0]];

   int vec = 0, errs = 0;
   logic [7:0]  txq [$];
   logic [63:0] wq  [$];
   logic [7:0]  expq [$];
   int  en_cnt = 0, rst_cnt = 0, stab_err = 0;
   int  adv = 0, pc_base = 0, halt_after = 0;
   logic halt_force = 1'b0, tx_rand = 1'b0, en_s = 1'b0;
   logic prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;

   // CPU model: pc advances by 4 on each clock where enable was high.
   assign i_pc   = 32'(4 * (adv - pc_base));
   assign i_halt = halt_force | ((halt_after > 0) && ((adv - pc_base) >= halt_after));

   always @(negedge i_clk) begin
      if (o_tx_valid && i_tx_ready) txq.push_back(o_tx_data);
      if (prev_stall && (!o_tx_valid || o_tx_data !== prev_data)) stab_err++;
      prev_stall = o_tx_valid && !i_tx_ready;
      prev_data  = o_tx_data;
      if (o_imem_we) wq.push_back({o_imem_addr, o_imem_data});
      if (o_enable) en_cnt++;
      if (o_reset_mips) rst_cnt++;
      en_s = o_enable;
   end

   always @(posedge i_clk) begin
      #1;
      if (en_s && !i_reset) adv++;
      i_tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic rdy;
      int n;
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      n = 0;
      rdy = 1'b0;
      while (!rdy && n < 2000) begin
         @(negedge i_clk);
         rdy = o_rx_ready;
         @(posedge i_clk);
         #1;
         n++;
      end
      i_rx_valid = 1'b0;
      vec++;
      if (!rdy) begin errs++; $display("FAIL rx_timeout byte=%02h not accepted", b); end
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
   endtask

   task automatic randomize_env(input logic [31:0] regval, input logic use_reg);
      for (int i = 0; i < 32; i++) begin
         regs[i] = use_reg ? regval : $urandom;
         memw[i] = $urandom;
      end
      for (int i = 0; i < 4; i++) latw[i] = $urandom;
   endtask

   // Reference stream: every word MSB first, then XOR of all preceding bytes.
   task automatic build_expected();
      logic [31:0] w;
      logic [7:0]  cs;
      expq.delete();
      cs = 8'h00;
      for (int i = 0; i < 68; i++) begin
         w = (i < 32) ? regs[i] : (i < 36) ? latw[i-32] : memw[i-36];
         for (int b = 3; b >= 0; b--) begin
            expq.push_back(w[8*b +: 8]);
            cs ^= w[8*b +: 8];
         end
      end
      expq.push_back(cs);
   endtask

   task automatic check_dump(input string tag);
      int n;
      n = 0;
      build_expected();
      while (txq.size() < 273 && n < 8000) begin cyc(1); n++; end
      cyc(6);
      vec++;
      if (txq.size() != 273) begin
         errs++; $display("FAIL %s dump_len got=%0d want=273", tag, txq.size());
      end
      for (int i = 0; i < 273 && i < txq.size(); i++) begin
         vec++;
         if (txq[i] !== expq[i]) begin
            errs++; $display("FAIL %s dump_byte[%0d] got=%02h want=%02h", tag, i, txq[i], expq[i]);
         end
      end
      vec++;
      if (o_tx_valid !== 1'b0) begin errs++; $display("FAIL %s tx_valid_after got=%b want=0", tag, o_tx_valid); end
      txq.delete();
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      cyc(3);
      @(negedge i_clk);
      vec++; if (o_rx_ready !== 1'b0)  begin errs++; $display("FAIL rst rx_ready got=%b want=0", o_rx_ready); end
      vec++; if (o_tx_valid !== 1'b0)  begin errs++; $display("FAIL rst tx_valid got=%b want=0", o_tx_valid); end
      vec++; if (o_tx_data !== 8'h00)  begin errs++; $display("FAIL rst tx_data got=%02h want=00", o_tx_data); end
      vec++; if (o_enable !== 1'b0)    begin errs++; $display("FAIL rst enable got=%b want=0", o_enable); end
      vec++; if (o_imem_we !== 1'b0)   begin errs++; $display("FAIL rst imem_we got=%b want=0", o_imem_we); end
      vec++; if (o_imem_addr !== 32'h0) begin errs++; $display("FAIL rst imem_addr got=%h want=0", o_imem_addr); end
      vec++; if (o_imem_data !== 32'h0) begin errs++; $display("FAIL rst imem_data got=%h want=0", o_imem_data); end
      vec++; if (o_rd_idx !== 32'h0)   begin errs++; $display("FAIL rst rd_idx got=%h want=0", o_rd_idx); end
      vec++; if (o_reset_mips !== 1'b0) begin errs++; $display("FAIL rst reset_mips got=%b want=0", o_reset_mips); end
      cyc(1);
      i_reset = 1'b0;
      cyc(1);
      vec++; if (o_rx_ready !== 1'b1)  begin errs++; $display("FAIL rst idle_rx_ready got=%b want=1", o_rx_ready); end
   endtask

   task automatic test_load();
      logic [31:0] words [$];
      logic [31:0] w;
      int k;
      wq.delete();
      send_byte(8'h04);
      send_word(32'h20010005);
      send_word(32'h0000003F);
      cyc(3);
      vec++; if (wq.size() != 2) begin errs++; $display("FAIL load wr_count got=%0d want=2", wq.size()); end
      if (wq.size() >= 2) begin
         vec++; if (wq[0] !== {32'h0, 32'h20010005}) begin errs++; $display("FAIL load wr0 got=%h want=%h", wq[0], {32'h0, 32'h20010005}); end
         vec++; if (wq[1] !== {32'h4, 32'h3F}) begin errs++; $display("FAIL load wr1 got=%h want=%h", wq[1], {32'h4, 32'h3F}); end
      end
      vec++; if (o_imem_addr !== 32'h0) begin errs++; $display("FAIL load addr_cleared got=%h want=0", o_imem_addr); end
      vec++; if (o_rx_ready !== 1'b1)   begin errs++; $display("FAIL load back_idle rx_ready got=%b want=1", o_rx_ready); end
      // Randomized program of k words terminated by the halt word.
      wq.delete();
      k = $urandom_range(1, 6);
      for (int i = 0; i < k; i++) begin
         w = $urandom;
         if (w == 32'h3F) w = 32'h40;
         words.push_back(w);
      end
      words.push_back(32'h3F);
      send_byte(8'h04);
      foreach (words[i]) send_word(words[i]);
      cyc(3);
      vec++; if (wq.size() != words.size()) begin errs++; $display("FAIL rload wr_count got=%0d want=%0d", wq.size(), words.size()); end
      for (int i = 0; i < words.size() && i < wq.size(); i++) begin
         vec++;
         if (wq[i] !== {32'(4*i), words[i]}) begin errs++; $display("FAIL rload wr[%0d] got=%h want=%h", i, wq[i], {32'(4*i), words[i]}); end
      end
   endtask

   task automatic test_step_backpressure();
      int e0;
      randomize_env(32'hA5A5A5A5, 1'b1);
      tx_rand = 1'b1;
      stab_err = 0;
      e0 = en_cnt;
      send_byte(8'h05);
      check_dump("step");
      tx_rand = 1'b0;
      vec++; if (en_cnt - e0 != 1) begin errs++; $display("FAIL step enable_cycles got=%0d want=1", en_cnt - e0); end
      vec++; if (stab_err != 0) begin errs++; $display("FAIL step tx_hold_stable got=%0d want=0 violations", stab_err); end
   endtask

   task automatic test_breakpoint();
      int e0;
      randomize_env(32'h0, 1'b0);
      send_byte(8'h0E);
      send_word(32'h00000008);
      pc_base = adv;
      e0 = en_cnt;
      send_byte(8'h03);
      check_dump("brk");
      vec++; if (en_cnt - e0 != 2) begin errs++; $display("FAIL brk enable_cycles got=%0d want=2", en_cnt - e0); end
      vec++; if (i_pc !== 32'h8) begin errs++; $display("FAIL brk stop_pc got=%h want=8", i_pc); end
      send_byte(8'h0E);
      send_word(32'hFFFFFFFF);
   endtask

   task automatic test_run_halt();
      int e0, r0;
      randomize_env(32'h0, 1'b0);
      pc_base = adv;
      halt_after = 10;
      e0 = en_cnt;
      send_byte(8'h03);
      check_dump("halt");
      vec++; if (en_cnt - e0 != 10) begin errs++; $display("FAIL halt enable_cycles got=%0d want=10", en_cnt - e0); end
      // Step while halted: dump only, no advance.
      e0 = en_cnt;
      send_byte(8'h05);
      check_dump("step_halted");
      vec++; if (en_cnt - e0 != 0) begin errs++; $display("FAIL step_halted enable_cycles got=%0d want=0", en_cnt - e0); end
      halt_after = 0;
      // Breakpoint must survive a CPU reset.
      send_byte(8'h0E);
      send_word(32'h00000004);
      r0 = rst_cnt;
      send_byte(8'h0C);
      cyc(3);
      vec++; if (rst_cnt - r0 != 1) begin errs++; $display("FAIL rstcpu pulses got=%0d want=1", rst_cnt - r0); end
      vec++; if (txq.size() != 0) begin errs++; $display("FAIL rstcpu tx_bytes got=%0d want=0", txq.size()); end
      pc_base = adv;
      e0 = en_cnt;
      send_byte(8'h03);
      check_dump("brk_kept");
      vec++; if (en_cnt - e0 != 1) begin errs++; $display("FAIL brk_kept enable_cycles got=%0d want=1", en_cnt - e0); end
      send_byte(8'h0E);
      send_word(32'hFFFFFFFF);
   endtask

   task automatic test_unknown_cmd();
      int e0;
      randomize_env(32'h0, 1'b0);
      e0 = en_cnt;
      send_byte(8'h77);
      cyc(10);
      vec++; if (txq.size() != 0) begin errs++; $display("FAIL unk tx_bytes got=%0d want=0", txq.size()); end
      vec++; if (o_rx_ready !== 1'b1) begin errs++; $display("FAIL unk back_idle got=%b want=1", o_rx_ready); end
      send_byte(8'h0F);
      check_dump("dumpcmd");
      vec++; if (en_cnt - e0 != 0) begin errs++; $display("FAIL dumpcmd enable_cycles got=%0d want=0", en_cnt - e0); end
   endtask

   task automatic test_reset_midload();
      logic [31:0] w;
      send_byte(8'h04);
      send_byte(8'hDE);
      send_byte(8'hAD);
      i_reset = 1'b1;
      cyc(2);
      i_reset = 1'b0;
      cyc(1);
      wq.delete();
      w = {8'h12, 8'($urandom), 8'($urandom), 8'($urandom)};
      send_byte(8'h04);
      send_word(w);
      send_word(32'h3F);
      cyc(3);
      vec++; if (wq.size() != 2) begin errs++; $display("FAIL midload wr_count got=%0d want=2", wq.size()); end
      if (wq.size() >= 2) begin
         vec++; if (wq[0] !== {32'h0, w}) begin errs++; $display("FAIL midload wr0 got=%h want=%h", wq[0], {32'h0, w}); end
         vec++; if (wq[1] !== {32'h4, 32'h3F}) begin errs++; $display("FAIL midload wr1 got=%h want=%h", wq[1], {32'h4, 32'h3F}); end
      end
   endtask

   task automatic test_reset_middump();
      int n;
      randomize_env(32'h0, 1'b0);
      send_byte(8'h0F);
      n = 0;
      while (txq.size() < 20 && n < 500) begin cyc(1); n++; end
      i_reset = 1'b1;
      cyc(2);
      i_reset = 1'b0;
      cyc(2);
      vec++; if (o_tx_valid !== 1'b0) begin errs++; $display("FAIL middump tx_valid got=%b want=0", o_tx_valid); end
      vec++; if (o_rd_idx !== 32'h0) begin errs++; $display("FAIL middump rd_idx got=%h want=0", o_rd_idx); end
      txq.delete();
      send_byte(8'h0F);
      check_dump("after_rst");
   endtask

   initial begin
      test_reset();
      test_load();
      test_step_backpressure();
      test_breakpoint();
      test_run_halt();
      test_unknown_cmd();
      test_reset_midload();
      test_reset_middump();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
